// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared CPU constants: instruction field layout, default
//                fetch widths and the fetch FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int DEF_PC_W    = 5;
    localparam int DEF_INSTR_W = 32;

    localparam int OPC_W = 4;
    localparam int REG_W = 5;
    localparam int IMM_W = 13;

    // Field LSB positions: opcode [31:28], rd [27:23], rs [22:18], rt [17:13], imm [12:0]
    localparam int OPC_LSB = 28;
    localparam int RD_LSB  = 23;
    localparam int RS_LSB  = 18;
    localparam int RT_LSB  = 13;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_pc_reg.sv
// ============================================================================
//  Module      : fetch_pc_reg
//  Description : Program counter with reset, hold, wrapping increment and
//                redirect load (redirect has priority over increment).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_reg
    import cpu_pkg::*;
#(
    parameter int PC_W     = DEF_PC_W,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_redirect,
    input  logic [PC_W-1:0] i_redirect_pc,
    input  logic            i_incr,
    output logic [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] r_pc;

    // Increment wraps naturally at 2**PC_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= PC_W'(RESET_PC);
        end else if (i_redirect) begin
            r_pc <= i_redirect_pc;
        end else if (i_incr) begin
            r_pc <= r_pc + PC_W'(1);
        end
    end

    assign o_pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage: PC, IF/ID register with valid/ready
//                handoff, redirect/flush and saturating issue counter.
//                Optional macro FETCH_HALT_EN: stop fetching on an all-zero word.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import cpu_pkg::*;
#(
    parameter int PC_W     = DEF_PC_W,
    parameter int INSTR_W  = DEF_INSTR_W,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    output logic [PC_W-1:0]    pc_o,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [INSTR_W-1:0] out_instr_o,
    output logic [PC_W-1:0]    out_pc_o,
    output logic [CNT_W-1:0]   issued_cnt_o,
    output logic               halted_o
);

    fetch_state_t       r_state;
    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_out_pc;
    logic [CNT_W-1:0]   r_cnt;

    logic w_redirect;
    logic w_slot;
    logic w_halt;
    logic w_load;
    logic w_xfer;

    // Redirect is only honoured once fetching has started.
    assign w_redirect = redirect_i && (r_state != IDLE);
    assign w_slot     = (r_state == RUN) && !redirect_i && (!r_valid || out_ready_i);
`ifdef FETCH_HALT_EN
    assign w_halt     = w_slot && (instr_i == '0);
`else
    assign w_halt     = 1'b0;
`endif
    assign w_load     = w_slot && !w_halt;
    assign w_xfer     = r_valid && out_ready_i;

    fetch_pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk           (clk),
        .rst           (rst),
        .i_redirect    (w_redirect),
        .i_redirect_pc (redirect_pc_i),
        .i_incr        (w_load),
        .o_pc          (pc_o)
    );

`ifdef FETCH_HALT_EN
    logic r_halted;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
`ifdef FETCH_HALT_EN
            r_halted <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_halt) begin
                        r_state  <= HALTED;
`ifdef FETCH_HALT_EN
                        r_halted <= 1'b1;
`endif
                    end
                end
                HALTED: begin
                    if (redirect_i) begin
                        r_state  <= RUN;
`ifdef FETCH_HALT_EN
                        r_halted <= 1'b0;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // IF/ID register: flush beats load, load beats drain; stall holds everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_instr  <= '0;
            r_out_pc <= '0;
        end else if (w_redirect) begin
            r_valid  <= 1'b0;
        end else if (w_load) begin
            r_valid  <= 1'b1;
            r_instr  <= instr_i;
            r_out_pc <= pc_o;
        end else if (out_ready_i) begin
            r_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_xfer && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out_valid_o  = r_valid;
    assign out_instr_o  = r_instr;
    assign out_pc_o     = r_out_pc;
    assign issued_cnt_o = r_cnt;
`ifdef FETCH_HALT_EN
    assign halted_o     = r_halted;
`else
    assign halted_o     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit: directed scenarios plus
//                randomized traffic against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    localparam int PC_W    = 5;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               start_i;
    logic [PC_W-1:0]    pc_o;
    logic [INSTR_W-1:0] instr_i;
    logic               redirect_i;
    logic [PC_W-1:0]    redirect_pc_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [INSTR_W-1:0] out_instr_o;
    logic [PC_W-1:0]    out_pc_o;
    logic [CNT_W-1:0]   issued_cnt_o;
    logic               halted_o;

    logic [INSTR_W-1:0] mem [32];
    assign instr_i = mem[pc_o];

    always #5 clk = ~clk;

    fetch_unit #(
        .PC_W     (PC_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (0),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .pc_o          (pc_o),
        .instr_i       (instr_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_instr_o   (out_instr_o),
        .out_pc_o      (out_pc_o),
        .issued_cnt_o  (issued_cnt_o),
        .halted_o      (halted_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: 0=not started, 1=fetching, 2=stopped on a zero word.
    int              m_mode;
    logic [PC_W-1:0] m_pc;
    bit              m_v;
    logic [31:0]     m_instr;
    logic [PC_W-1:0] m_out_pc;
    int              m_cnt;
    bit              m_halted;

    task automatic model_step();
        logic [31:0] word;
        bit          slot;
        if (rst) begin
            m_mode = 0; m_pc = 0; m_v = 0; m_instr = 0; m_out_pc = 0; m_cnt = 0; m_halted = 0;
            return;
        end
        if (m_v && out_ready_i && m_cnt < CNT_MAX) m_cnt++;
        word = mem[m_pc];
        slot = (m_mode == 1) && (!m_v || out_ready_i);
        if (m_mode == 0) begin
            if (start_i) m_mode = 1;
        end else if (redirect_i) begin
            m_pc = redirect_pc_i; m_v = 0; m_mode = 1; m_halted = 0;
        end else if (slot && !(HALT_EN && word == 0)) begin
            m_instr = word; m_out_pc = m_pc; m_v = 1; m_pc = m_pc + 1'b1;
        end else begin
            if (slot) begin m_mode = 2; m_halted = 1; end
            if (out_ready_i) m_v = 0;
        end
    endtask

    task automatic compare_all();
        check("pc_o", pc_o, m_pc);
        check("out_valid_o", out_valid_o, m_v);
        check("out_instr_o", out_instr_o, m_instr);
        check("out_pc_o", out_pc_o, m_out_pc);
        check("issued_cnt_o", issued_cnt_o, m_cnt);
        check("halted_o", halted_o, m_halted);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; start_i = 1'b0; redirect_i = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; out_ready_i = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        mem[0] = 32'h1000_0001;
        mem[1] = 32'h5780_0000 | 32'hF;
        for (int i = 2; i < 6; i++) mem[i] = $urandom | 32'h1;

        // Reset state
        do_reset();
        check("rst_pc", pc_o, 0);
        check("rst_valid", out_valid_o, 0);
        check("rst_instr", out_instr_o, 0);
        check("rst_out_pc", out_pc_o, 0);
        check("rst_cnt", issued_cnt_o, 0);
        check("rst_halted", halted_o, 0);

        // Start with a simultaneous redirect: start wins, redirect ignored
        out_ready_i = 1'b1;
        redirect_i = 1'b1; redirect_pc_i = 5'd9;
        pulse_start();
        redirect_i = 1'b0;
        check("start_wins_pc", pc_o, 0);
        check("start_no_valid", out_valid_o, 0);
        tick();
        check("first_valid", out_valid_o, 1);
        check("first_pc", out_pc_o, 0);
        tick();
        check("pc1_pc", out_pc_o, 1);
        check("pc1_instr", out_instr_o, 32'h5780_000F);
        repeat (5) tick();
        check("cnt_after_6", issued_cnt_o, 6);
`ifdef FETCH_HALT_EN
        check("halt_flag", halted_o, 1);
        check("halt_pc", pc_o, 6);
        check("halt_drained", out_valid_o, 0);
        repeat (3) tick();
        check("halt_stays", halted_o, 1);
        check("halt_pc_hold", pc_o, 6);
        redirect_i = 1'b1; redirect_pc_i = 5'd0;
        tick();
        redirect_i = 1'b0;
        check("unhalt_flag", halted_o, 0);
        check("unhalt_pc", pc_o, 0);
        check("unhalt_valid", out_valid_o, 0);
        tick();
        check("resume_valid", out_valid_o, 1);
        check("resume_pc", out_pc_o, 0);
        repeat (8) tick();
`else
        check("no_halt_flag", halted_o, 0);
        check("zero_word_pc", out_pc_o, 6);
        check("zero_word_valid", out_valid_o, 1);
        repeat (26) tick();
        check("wrap_pc", out_pc_o, 0);
        check("wrap_instr", out_instr_o, 32'h1000_0001);
`endif
        check("cnt_saturated", issued_cnt_o, CNT_MAX);

        // Stall for 3 cycles with pc 2 in IF/ID
        do_reset();
        out_ready_i = 1'b1;
        pulse_start();
        for (int i = 0; i < 10 && !(m_v && m_out_pc == 2); i++) tick();
        check("reach_pc2", out_pc_o, 2);
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_out_pc", out_pc_o, 2);
            check("stall_pc", pc_o, 3);
            check("stall_instr", out_instr_o, mem[2]);
        end
        out_ready_i = 1'b1;
        tick();
        check("release_pc", out_pc_o, 3);

        // Redirect to 4 while pc 1 is being transferred
        do_reset();
        out_ready_i = 1'b1;
        pulse_start();
        for (int i = 0; i < 10 && !(m_v && m_out_pc == 1); i++) tick();
        check("reach_pc1", out_pc_o, 1);
        redirect_i = 1'b1; redirect_pc_i = 5'd4;
        tick();
        redirect_i = 1'b0;
        check("redir_flush", out_valid_o, 0);
        check("redir_cnt", issued_cnt_o, 2);
        check("redir_pc", pc_o, 4);
        tick();
        check("redir_target_valid", out_valid_o, 1);
        check("redir_target_pc", out_pc_o, 4);
        check("redir_target_instr", out_instr_o, mem[4]);

        // Reset mid-stream
        do_reset();
        out_ready_i = 1'b1;
        pulse_start();
        for (int i = 0; i < 10 && !(m_v && m_pc == 3); i++) tick();
        check("reach_fetch3", pc_o, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_pc", pc_o, 0);
        check("midrst_valid", out_valid_o, 0);
        check("midrst_cnt", issued_cnt_o, 0);
        repeat (3) tick();
        check("idle_pc", pc_o, 0);
        check("idle_valid", out_valid_o, 0);

        // Randomized traffic
        for (int i = 0; i < 32; i++) mem[i] = ($urandom_range(0, 5) == 0) ? 32'h0 : ($urandom | 32'h1);
        do_reset();
        pulse_start();
        for (int i = 0; i < 600; i++) begin
            out_ready_i   = ($urandom_range(0, 3) != 0);
            redirect_i    = ($urandom_range(0, 9) == 0);
            redirect_pc_i = PC_W'($urandom);
            start_i       = ($urandom_range(0, 19) == 0);
            rst           = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0; start_i = 1'b0; redirect_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
